// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_if
//  Description : Instruction-in / write-request-out bundle of the execute ALU.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
);
    localparam int AW = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] read_reg0;
    logic [DATA_WIDTH-1:0] read_reg1;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic [3:0]            opcode;
    logic [10:0]           immd;

    logic                  reg_write_en;
    int unsigned           reg_write_idx;
    logic [DATA_WIDTH-1:0] reg_write_data;
    logic                  mem_write_en;
    logic [AW-1:0]         mem_write_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;

    // Issuing side: decode stage driving instructions in, consuming write requests.
    modport master (
        output read_reg0, read_reg1, mem_read_data, opcode, immd,
        input  reg_write_en, reg_write_idx, reg_write_data,
        input  mem_write_en, mem_write_addr, mem_write_data
    );

    modport slave (
        input  read_reg0, read_reg1, mem_read_data, opcode, immd,
        output reg_write_en, reg_write_idx, reg_write_data,
        output mem_write_en, mem_write_addr, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Scalar execute stage; combinational datapath, one output register.
//  Revision    : 1.0  initial release
// ============================================================================
module alu #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_if.slave      bus
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_MIN   = 4'd5;
    localparam logic [3:0] OP_MAX   = 4'd6;
    localparam logic [3:0] OP_AND   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_XOR   = 4'd9;
    localparam logic [3:0] OP_XNOR  = 4'd10;
    localparam logic [3:0] OP_LOAD  = 4'd11;
    localparam logic [3:0] OP_STORE = 4'd12;

    logic [DATA_WIDTH-1:0] a, b;
    logic [DATA_WIDTH-1:0] result;
    logic                  is_reg_op;

    logic                  reg_we_d, reg_we_q;
    int unsigned           reg_idx_d, reg_idx_q;
    logic [DATA_WIDTH-1:0] reg_data_d, reg_data_q;
    logic                  mem_we_d, mem_we_q;
    logic [AW-1:0]         mem_addr_d, mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_d, mem_data_q;

    assign a = bus.read_reg0;
    assign b = bus.read_reg1;

    // Divide-by-zero saturates to all ones instead of trapping.
    always_comb begin
        result    = '0;
        is_reg_op = 1'b1;
        case (bus.opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_DIV:  result = (b == '0) ? '1 : (a / b);
            OP_MIN:  result = (b < a) ? b : a;
            OP_MAX:  result = (b > a) ? b : a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_XNOR: result = ~(a ^ b);
            OP_LOAD: result = bus.mem_read_data;
            default: is_reg_op = 1'b0;
        endcase
    end

    // Idle companions are forced to zero so only the active request carries data.
    always_comb begin
        reg_we_d   = 1'b0;
        reg_idx_d  = '0;
        reg_data_d = '0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_data_d = '0;
        if (is_reg_op) begin
            reg_we_d   = 1'b1;
            reg_idx_d  = {29'd0, bus.immd[10:8]};
            reg_data_d = result;
        end else if (bus.opcode == OP_STORE) begin
            mem_we_d   = 1'b1;
            mem_addr_d = bus.immd[AW-1:0];
            mem_data_d = a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_we_q   <= 1'b0;
            reg_idx_q  <= '0;
            reg_data_q <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            reg_we_q   <= reg_we_d;
            reg_idx_q  <= reg_idx_d;
            reg_data_q <= reg_data_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    assign bus.reg_write_en   = reg_we_q;
    assign bus.reg_write_idx  = reg_idx_q;
    assign bus.reg_write_data = reg_data_q;
    assign bus.mem_write_en   = mem_we_q;
    assign bus.mem_write_addr = mem_addr_q;
    assign bus.mem_write_data = mem_data_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu
//  Description : Self-checking bench for alu: directed steps plus random stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu;
    typedef struct packed {
        logic        rwe;
        logic [31:0] ridx;
        logic [31:0] rdata;
        logic        mwe;
        logic [7:0]  maddr;
        logic [31:0] mdata;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_if #(.DATA_WIDTH(32), .MEM_DEPTH(256)) bus ();

    alu #(.DATA_WIDTH(32), .MEM_DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference behaviour from the opcode table, in 64-bit arithmetic reduced mod 2^32.
    function automatic exp_t model(input int op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] m, input logic [10:0] im);
        exp_t e;
        longint unsigned x, y, r;
        bit wr;
        e  = '0;
        x  = longint'(a);
        y  = longint'(b);
        r  = 0;
        wr = 1'b1;
        case (op)
            1:  r = x + y;
            2:  r = x + 64'h1_0000_0000 - y;
            3:  r = x * y;
            4:  r = (y == 0) ? 64'hFFFF_FFFF : x / y;
            5:  r = (y < x) ? y : x;
            6:  r = (y > x) ? y : x;
            7:  r = x & y;
            8:  r = x | y;
            9:  r = x ^ y;
            10: r = ~(x ^ y);
            11: r = longint'(m);
            default: wr = 1'b0;
        endcase
        if (wr) begin
            e.rwe   = 1'b1;
            e.rdata = r[31:0];
            e.ridx  = 32'(im) / 256;
        end else if (op == 12) begin
            e.mwe   = 1'b1;
            e.maddr = 8'(32'(im) % 256);
            e.mdata = a;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".reg_write_en"},   32'(bus.reg_write_en),   32'(e.rwe));
        chk({tag, ".reg_write_idx"},  bus.reg_write_idx,       e.ridx);
        chk({tag, ".reg_write_data"}, bus.reg_write_data,      e.rdata);
        chk({tag, ".mem_write_en"},   32'(bus.mem_write_en),   32'(e.mwe));
        chk({tag, ".mem_write_addr"}, 32'(bus.mem_write_addr), 32'(e.maddr));
        chk({tag, ".mem_write_data"}, bus.mem_write_data,      e.mdata);
    endtask

    // Drive on the falling edge, then sample just after the rising edge that captures it.
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] m, input logic [10:0] im);
        @(negedge clk);
        bus.opcode        = 4'(op);
        bus.read_reg0     = a;
        bus.read_reg1     = b;
        bus.mem_read_data = m;
        bus.immd          = im;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t regw(input logic [31:0] idx, input logic [31:0] d);
        exp_t e;
        e       = '0;
        e.rwe   = 1'b1;
        e.ridx  = idx;
        e.rdata = d;
        return e;
    endfunction

    function automatic exp_t memw(input logic [7:0] ad, input logic [31:0] d);
        exp_t e;
        e       = '0;
        e.mwe   = 1'b1;
        e.maddr = ad;
        e.mdata = d;
        return e;
    endfunction

    initial begin
        exp_t zero;
        zero                = '0;
        checks              = 0;
        errors              = 0;
        rst_n               = 1'b0;
        bus.opcode          = 4'd0;
        bus.read_reg0       = '0;
        bus.read_reg1       = '0;
        bus.mem_read_data   = '0;
        bus.immd            = '0;

        // Reset held for two edges with a STORE pending: nothing may come out.
        issue(12, 32'hAAAA_5555, 32'h1, 32'h0, 11'h012);
        chk_all("reset0", zero);
        issue(12, 32'hAAAA_5555, 32'h1, 32'h0, 11'h012);
        chk_all("reset1", zero);
        @(negedge clk);
        rst_n = 1'b1;
        issue(12, 32'hCAFE_0001, 32'h0, 32'h0, 11'h012);
        chk_all("first_store", memw(8'h12, 32'hCAFE_0001));

        // Directed arithmetic.
        issue(1, 32'd7, 32'd3, 32'h0, 11'h500);
        chk_all("add", regw(5, 32'd10));
        issue(2, 32'd7, 32'd3, 32'h0, 11'h500);
        chk_all("sub", regw(5, 32'd4));
        issue(2, 32'd3, 32'd7, 32'h0, 11'h500);
        chk_all("sub_wrap", regw(5, 32'hFFFF_FFFC));
        issue(3, 32'h0001_0001, 32'h0001_0000, 32'h0, 11'h500);
        chk_all("mul_low", regw(5, 32'h0001_0000));
        issue(4, 32'd7, 32'd3, 32'h0, 11'h500);
        chk_all("div", regw(5, 32'd2));
        issue(4, 32'd5, 32'd0, 32'h0, 11'h500);
        chk_all("div_zero", regw(5, 32'hFFFF_FFFF));
        issue(5, 32'h8000_0000, 32'd1, 32'h0, 11'h500);
        chk_all("min_unsigned", regw(5, 32'd1));
        issue(6, 32'h8000_0000, 32'd1, 32'h0, 11'h500);
        chk_all("max_unsigned", regw(5, 32'h8000_0000));
        issue(10, 32'd0, 32'd0, 32'h0, 11'h500);
        chk_all("xnor_zero", regw(5, 32'hFFFF_FFFF));
        issue(11, 32'h1, 32'h2, 32'hDEAD_BEEF, 11'h3FF);
        chk_all("load", regw(3, 32'hDEAD_BEEF));
        issue(12, 32'h1234_5678, 32'h9, 32'h0, 11'd1024);
        chk_all("store_wrap", memw(8'd0, 32'h1234_5678));
        issue(12, 32'h1234_5678, 32'h9, 32'h0, 11'd300);
        chk_all("store_300", memw(8'd44, 32'h1234_5678));

        // Idle opcodes and a one-cycle strobe in a back-to-back stream.
        issue(0, 32'h5, 32'h6, 32'h7, 11'h7FF);
        chk_all("nop", zero);
        issue(14, 32'h5, 32'h6, 32'h7, 11'h7FF);
        chk_all("matmul", zero);
        issue(1, 32'd1, 32'd2, 32'h0, 11'h000);
        chk_all("stream_add", regw(0, 32'd3));
        issue(0, 32'd1, 32'd2, 32'h0, 11'h000);
        chk_all("stream_nop", zero);
        issue(13, 32'd1, 32'd2, 32'h0, 11'h7FF);
        chk_all("matadd", zero);
        issue(15, 32'd1, 32'd2, 32'h0, 11'h7FF);
        chk_all("undef15", zero);

        // Reset mid-stream drops the in-flight ADD.
        @(negedge clk);
        rst_n = 1'b0;
        issue(1, 32'd9, 32'd9, 32'h0, 11'h100);
        chk_all("reset_mid", zero);
        @(negedge clk);
        rst_n = 1'b1;

        // Random stream against the reference model.
        for (int i = 0; i < 1000; i++) begin
            int          op;
            logic [31:0] a, b, m;
            logic [10:0] im;
            op = int'($urandom_range(0, 12));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            m  = $urandom;
            im = 11'($urandom_range(0, 2047));
            issue(op, a, b, m, im);
            chk_all($sformatf("rand%0d_op%0d", i, op), model(op, a, b, m, im));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
